// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the shared memory and the arbiter.
// The arbiter connects through the slave modport; requesters and the memory use master.
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported synchronous memory between the fetch (I) and load/store (D)
// requesters, one transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> IDLE.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,  // must be >= 1
  parameter int unsigned ARB_MODE = 0   // 0: round-robin, 1: D has fixed priority
) (
  input logic                clk,
  input logic                rst_n,
  imem_dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_gnt_d_q;
  logic              owner_d_q;
  logic              owner_we_q;

  logic              i_gnt_q;
  logic              d_gnt_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic any_req;
  logic win_d;

  // Contested requests go to D in fixed mode, else to the port not granted last time.
  always_comb begin
    any_req = bus.i_req | bus.d_req;
    if (bus.i_req && bus.d_req) begin
      win_d = (ARB_MODE == 1) ? 1'b1 : !last_gnt_d_q;
    end else begin
      win_d = bus.d_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_gnt_d_q <= 1'b1;
      owner_d_q    <= 1'b0;
      owner_we_q   <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them for one cycle.
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StIssue;
            last_gnt_d_q <= win_d;
            owner_d_q    <= win_d;
            owner_we_q   <= win_d & bus.d_we;
            i_gnt_q      <= !win_d;
            d_gnt_q      <= win_d;
            mem_en_q     <= 1'b1;
            mem_we_q     <= win_d & bus.d_we;
            mem_addr_q   <= win_d ? bus.d_addr : bus.i_addr;
            mem_wdata_q  <= win_d ? bus.d_wdata : '0;
          end
        end

        StIssue: begin
          state_q <= StWait;
          cnt_q   <= CntLoad;
        end

        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            if (owner_d_q) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= owner_we_q ? '0 : bus.mem_rdata;
            end else begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: three configurations, a directed vector table, hand-written
// corner sequences and randomized traffic checked against a transaction-level model.
module tb_imem_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_req   = 1'b0;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] i_addr  = '0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] mem_rdata;
  int            sel     = 0;
  int            lat     = 1;
  int            mode    = 0;

  int n_vec = 0;
  int n_bad = 0;

  // cfg0: MEM_LAT=1 round-robin, cfg1: MEM_LAT=2 round-robin, cfg2: MEM_LAT=3 fixed D.
  imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .ARB_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .ARB_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.i_req = i_req && (sel == 0);
  assign bus1.i_req = i_req && (sel == 1);
  assign bus2.i_req = i_req && (sel == 2);
  assign bus0.d_req = d_req && (sel == 0);
  assign bus1.d_req = d_req && (sel == 1);
  assign bus2.d_req = d_req && (sel == 2);
  assign bus0.i_addr = i_addr;
  assign bus1.i_addr = i_addr;
  assign bus2.i_addr = i_addr;
  assign bus0.d_addr = d_addr;
  assign bus1.d_addr = d_addr;
  assign bus2.d_addr = d_addr;
  assign bus0.d_we = d_we;
  assign bus1.d_we = d_we;
  assign bus2.d_we = d_we;
  assign bus0.d_wdata = d_wdata;
  assign bus1.d_wdata = d_wdata;
  assign bus2.d_wdata = d_wdata;
  assign bus0.mem_rdata = mem_rdata;
  assign bus1.mem_rdata = mem_rdata;
  assign bus2.mem_rdata = mem_rdata;

  typedef struct packed {
    logic          i_gnt;
    logic          d_gnt;
    logic          i_rvalid;
    logic          d_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] i_rdata;
    logic [DW-1:0] d_rdata;
  } obs_t;

  obs_t o;
  always_comb begin
    case (sel)
      1: o = {bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid, bus1.mem_en, bus1.mem_we,
              bus1.busy, bus1.mem_addr, bus1.mem_wdata, bus1.i_rdata, bus1.d_rdata};
      2: o = {bus2.i_gnt, bus2.d_gnt, bus2.i_rvalid, bus2.d_rvalid, bus2.mem_en, bus2.mem_we,
              bus2.busy, bus2.mem_addr, bus2.mem_wdata, bus2.i_rdata, bus2.d_rdata};
      default: o = {bus0.i_gnt, bus0.d_gnt, bus0.i_rvalid, bus0.d_rvalid, bus0.mem_en,
                    bus0.mem_we, bus0.busy, bus0.mem_addr, bus0.mem_wdata, bus0.i_rdata,
                    bus0.d_rdata};
    endcase
  end

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'h00A0_0513 : {16'hC0DE, 8'h00, a};
  endfunction

  // Memory environment: data is valid only in the cycle lat edges after the sampling edge.
  bit [DW-1:0]   env_mem [256];
  bit            env_wr  [256];
  int unsigned   cyc    = 0;
  int unsigned   rd_cyc = 0;
  logic [DW-1:0] rd_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o.mem_en) begin
      rd_cyc <= cyc + lat;
      rd_val <= env_wr[o.mem_addr[7:0]] ? env_mem[o.mem_addr[7:0]] : init_word(o.mem_addr[7:0]);
      if (o.mem_we) begin
        env_mem[o.mem_addr[7:0]] <= o.mem_wdata;
        env_wr[o.mem_addr[7:0]]  <= 1'b1;
      end
    end
  end

  assign mem_rdata = (cyc == rd_cyc) ? rd_val : (32'hBAD0_0000 ^ cyc);

  task automatic chk_obs(input string name, input obs_t exp);
    n_vec++;
    if (o !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, o, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // flags = {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy}
  function automatic obs_t mk(input logic [6:0] flags, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] ird,
                              input logic [DW-1:0] drd);
    return {flags, a, wd, ird, drd};
  endfunction

  task automatic start_cfg(input int s);
    rst_n   = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    sel     = s;
    lat     = s + 1;
    mode    = (s == 2) ? 1 : 0;
    @(negedge clk);
    chk_obs($sformatf("reset state cfg%0d", s), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Transaction-level reference: one outstanding access, next sample LAT+2 cycles later.
  bit [DW-1:0]   rm   [256];
  bit            rm_w [256];
  int            m_free;
  bit            m_last_d;
  int            t_g;
  int            t_r;
  bit            t_d;
  bit            t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;
  logic [DW-1:0] t_rd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;
  logic [DW-1:0] h_ird;
  logic [DW-1:0] h_drd;

  task automatic model_reset();
    m_free   = 0;
    m_last_d = 1'b1;
    t_g      = -100;
    t_r      = -100;
    h_addr   = '0;
    h_wd     = '0;
    h_ird    = '0;
    h_drd    = '0;
  endtask

  task automatic model_expect(input int c, output obs_t e);
    e = '0;
    if (c == t_g) begin
      e.i_gnt  = !t_d;
      e.d_gnt  = t_d;
      e.mem_en = 1'b1;
      e.mem_we = t_we;
      h_addr   = t_addr;
      h_wd     = t_wd;
    end
    if (c == t_r) begin
      if (t_d) begin
        e.d_rvalid = 1'b1;
        h_drd      = t_rd;
      end else begin
        e.i_rvalid = 1'b1;
        h_ird      = t_rd;
      end
    end
    e.busy      = (c >= t_g) && (c < t_r);
    e.mem_addr  = h_addr;
    e.mem_wdata = h_wd;
    e.i_rdata   = h_ird;
    e.d_rdata   = h_drd;
  endtask

  task automatic model_sample(input int c);
    bit win_d;
    if (c >= m_free && (i_req || d_req)) begin
      if (i_req && d_req) win_d = (mode == 1) ? 1'b1 : !m_last_d;
      else                win_d = d_req;
      m_last_d = win_d;
      t_g      = c + 1;
      t_r      = c + 2 + lat;
      m_free   = t_r;
      t_d      = win_d;
      t_we     = win_d && d_we;
      t_addr   = win_d ? d_addr : i_addr;
      t_wd     = win_d ? d_wdata : '0;
      if (t_we) begin
        rm[t_addr[7:0]]   = d_wdata;
        rm_w[t_addr[7:0]] = 1'b1;
        t_rd              = '0;
      end else begin
        t_rd = rm_w[t_addr[7:0]] ? rm[t_addr[7:0]] : init_word(t_addr[7:0]);
      end
    end
  endtask

  typedef struct {
    logic ireq;
    logic dreq;
    obs_t exp;
  } vec_t;

  initial begin
    vec_t tv [14];
    obs_t e;
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    bit saw_ig;
    bit saw_dg;

    wa = 32'h00A0_0513;
    wb = 32'hC0DE_0010;
    // Contention from reset on cfg0: grants I,D,I,D at 1,4,7,10, rvalids at 3,6,9,12.
    tv[0]  = '{1'b1, 1'b1, mk(7'b0000000, 16'h0000, '0, '0, '0)};
    tv[1]  = '{1'b1, 1'b1, mk(7'b1000101, 16'h0004, '0, '0, '0)};
    tv[2]  = '{1'b1, 1'b1, mk(7'b0000001, 16'h0004, '0, '0, '0)};
    tv[3]  = '{1'b1, 1'b1, mk(7'b0010000, 16'h0004, '0, wa, '0)};
    tv[4]  = '{1'b1, 1'b1, mk(7'b0100101, 16'h0010, '0, wa, '0)};
    tv[5]  = '{1'b1, 1'b1, mk(7'b0000001, 16'h0010, '0, wa, '0)};
    tv[6]  = '{1'b1, 1'b1, mk(7'b0001000, 16'h0010, '0, wa, wb)};
    tv[7]  = '{1'b1, 1'b1, mk(7'b1000101, 16'h0004, '0, wa, wb)};
    tv[8]  = '{1'b1, 1'b1, mk(7'b0000001, 16'h0004, '0, wa, wb)};
    tv[9]  = '{1'b1, 1'b1, mk(7'b0010000, 16'h0004, '0, wa, wb)};
    tv[10] = '{1'b0, 1'b0, mk(7'b0100101, 16'h0010, '0, wa, wb)};
    tv[11] = '{1'b0, 1'b0, mk(7'b0000001, 16'h0010, '0, wa, wb)};
    tv[12] = '{1'b0, 1'b0, mk(7'b0001000, 16'h0010, '0, wa, wb)};
    tv[13] = '{1'b0, 1'b0, mk(7'b0000000, 16'h0010, '0, wa, wb)};

    start_cfg(0);
    i_addr = 16'h0004;
    d_addr = 16'h0010;
    for (int k = 0; k < 14; k++) begin
      i_req = tv[k].ireq;
      d_req = tv[k].dreq;
      @(negedge clk);
      chk_obs($sformatf("table c%0d", k), tv[k].exp);
      @(posedge clk);
      #1;
    end

    // Write then read back on cfg1 (MEM_LAT=2).
    start_cfg(1);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0010;
    d_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 9; c++) begin
      if (c == 2) d_req = 1'b0;
      if (c == 5) begin
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_wdata = '0;
      end
      if (c == 7) d_req = 1'b0;
      @(negedge clk);
      case (c)
        1: chk_obs("write gnt", mk(7'b0100111, 16'h0010, 32'hDEAD_BEEF, '0, '0));
        4: chk_obs("write ack", mk(7'b0001000, 16'h0010, 32'hDEAD_BEEF, '0, '0));
        6: chk_obs("read gnt", mk(7'b0100101, 16'h0010, '0, '0, '0));
        9: chk_obs("read back", mk(7'b0001000, 16'h0010, '0, '0, 32'hDEAD_BEEF));
        default: chk($sformatf("wr/rd quiet c%0d", c),
                     32'({o.i_gnt, o.d_gnt, o.i_rvalid, o.d_rvalid}), 32'h0);
      endcase
      @(posedge clk);
      #1;
    end
    rm[8'h10]   = 32'hDEAD_BEEF;
    rm_w[8'h10] = 1'b1;

    // Fixed priority on cfg2 (MEM_LAT=3): D every 5 cycles, I only once d_req drops.
    start_cfg(2);
    i_addr = 16'h0004;
    d_addr = 16'h0020;
    i_req  = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      d_req = (c < 20);
      @(negedge clk);
      chk($sformatf("fixed prio c%0d", c), 32'({o.i_gnt, o.d_gnt}),
          32'({c == 21, (c < 21) && (c % 5 == 1)}));
      @(posedge clk);
      #1;
    end
    i_req = 1'b0;

    // D request arriving while an I read is in flight on cfg0.
    start_cfg(0);
    i_addr = 16'h0008;
    d_addr = 16'h0011;
    for (int c = 0; c <= 6; c++) begin
      i_req = (c <= 1);
      d_req = (c >= 2) && (c <= 4);
      @(negedge clk);
      chk($sformatf("busy req c%0d", c), 32'({o.i_gnt, o.i_rvalid, o.d_gnt}),
          32'({c == 1, c == 3, c == 4}));
      if (c == 3) chk("busy req i_rdata", o.i_rdata, 32'hC0DE_0008);
      @(posedge clk);
      #1;
    end

    // Reset in cycle 2 of an I read: outputs drop at once, no late rvalid, then normal service.
    start_cfg(0);
    i_addr = 16'h0004;
    i_req  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    @(negedge clk);
    chk("abort gnt", 32'(o.i_gnt), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_obs("abort async reset", '0);
    @(negedge clk);
    chk_obs("abort in reset", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_obs($sformatf("abort quiet c%0d", c), '0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c <= 3; c++) begin
      i_req = (c <= 1);
      @(negedge clk);
      if (c == 1) chk_obs("after abort gnt", mk(7'b1000101, 16'h0004, '0, '0, '0));
      if (c == 3) chk_obs("after abort data", mk(7'b0010000, 16'h0004, '0, 32'h00A0_0513, '0));
      @(posedge clk);
      #1;
    end

    // Randomized traffic on every configuration.
    for (int s = 0; s < 3; s++) begin
      start_cfg(s);
      model_reset();
      saw_ig = 1'b0;
      saw_dg = 1'b0;
      for (int c = 0; c < 500; c++) begin
        if (!i_req || saw_ig) begin
          i_req  = ($urandom_range(0, 9) < 6);
          i_addr = 16'($urandom_range(0, 31));
        end
        if (!d_req || saw_dg) begin
          d_req   = ($urandom_range(0, 9) < 6);
          d_we    = $urandom_range(0, 1) == 1;
          d_addr  = 16'($urandom_range(0, 31));
          d_wdata = $urandom;
        end
        @(negedge clk);
        model_expect(c, e);
        chk_obs($sformatf("random cfg%0d c%0d", s, c), e);
        saw_ig = o.i_gnt;
        saw_dg = o.d_gnt;
        model_sample(c);
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch requester (I port) and the load/store requester (D port) of the multi-cycle processor.
- Arbitrates between the two ports and keeps exactly one transaction outstanding.
- Sequences each transaction through issue, wait and capture.
- Returns a registered response to the requester that was granted.

Parameters:
- ADDR_W, 16, word-address width on both ports and on the memory side.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in clock edges (must be ≥1).
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority to D.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  one-cycle pulse; fetch accepted.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DATA_W  fetched instruction word.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse; data request accepted.
- d_rvalid  out  1  one-cycle pulse; read data valid or write acknowledge.
- d_rdata  out  DATA_W  read data; 0 for a write acknowledge.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid MEM_LAT edges after the edge that samples mem_en=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: while rst_n=0, all outputs are 0, the FSM is IDLE, the wait counter is 0 and last_gnt = D (so the first contested grant goes to I). Reset takes effect immediately; it is not synchronised to clk.
- FSM states:
  - IDLE → ISSUE when i_req or d_req is sampled high.
  - ISSUE (exactly 1 cycle) → WAIT.
  - WAIT (exactly MEM_LAT cycles, driven by a down-counter) → IDLE.
- Requests are sampled only in IDLE. In every other state req is ignored and not queued.
- Arbitration at the IDLE sampling edge:
  - Single requester: that port wins.
  - Both requesting, ARB_MODE=0: the port ≠ last_gnt wins.
  - Both requesting, ARB_MODE=1: D wins.
  - last_gnt updates to the winner.
- At the IDLE sampling edge the winner's address, we and wdata are registered. I-port transactions use we=0 and wdata=0.
- ISSUE cycle:
  - mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven from the registered values.
  - The winner's gnt=1 for this cycle only.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- WAIT: on its final edge, mem_rdata is captured into the owner's rdata register and the owner's rvalid is set for one cycle.
  - For a write, rdata is loaded with 0 instead (acknowledge only).
  - The non-owner's rdata register holds its previous value.
- Timing:
  - Request sampled in cycle 0 → gnt and mem_en in cycle 1 → rvalid in cycle 2+MEM_LAT.
  - A request held high is re-sampled in the rvalid cycle.
  - Back-to-back period is MEM_LAT+2 cycles.
- Requesters keep req, addr, we and wdata stable from assertion until gnt is seen. They may hold req high to request again.
- Reset asserted mid-transaction aborts it: no rvalid is produced, and any later mem_rdata is ignored.
- There is no error path. Address width is truncated or zero-extended by the integrator, not inside this block.

Test Plan:
- Single read, MEM_LAT=1: i_req=1, i_addr=0x0004 in cycle 0, memory returns 0x00A0_0513 → i_gnt and mem_en=1 with mem_addr=0x0004 in cycle 1; i_rvalid=1, i_rdata=0x00A0_0513 in cycle 3; d_* stay 0.
- Write then read, MEM_LAT=2: d_we=1, d_addr=0x0010, d_wdata=0xDEAD_BEEF.
  - Write: d_gnt with mem_we=1 in cycle 1; d_rvalid=1 with d_rdata=0 in cycle 4.
  - Read back from the same address → d_rdata=0xDEAD_BEEF.
- Contention, ARB_MODE=0: both req held high from cycle 0.
  - Grants follow I, D, I, D at cycles 1, 4, 7, 10.
  - rvalid pulses land on the matching port at cycles 3, 6, 9, 12.
- Contention, ARB_MODE=1: both req held high → D is granted every time and I is never granted while d_req stays high. When d_req drops, I is granted on the next IDLE sample.
- Request during busy: d_req rises in cycle 2 while an I read is in flight → no d_gnt before the I rvalid (cycle 3); d_gnt in cycle 4.
- Reset mid-operation: rst_n=0 in cycle 2 of an I read → all outputs are 0 immediately; no i_rvalid afterwards; after release, a new request is served normally.
